// File: rtl/pixel_packer.sv
// pixel_packer
//   Packs a stream of 24-bit RGB pixels densely into 32-bit AXI4-Stream words
//   (4 pixels -> 3 words, byte stream R,G,B, stream byte k on tdata[8k+7:8k]).
//   Marks the first word of a frame with tuser and the last word of a line
//   with tlast, and pulses frame_done once the final word of a frame has been
//   accepted downstream.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   in_r/in_g/in_b         pixel colour components
//   in_valid / in_ready    pixel handshake (in_valid only legal while in_ready)
//   m_axis_tdata/tvalid/tready/tlast/tuser   packed AXI4-Stream master
//   frame_done             1-cycle pulse after the frame's last word handshake
module pixel_packer #(
    parameter int unsigned X_SIZE = 640,  // pixels per line, multiple of 4
    parameter int unsigned Y_SIZE = 480   // lines per frame
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        frame_done
);

    localparam int unsigned XW = $clog2(X_SIZE + 1);
    localparam int unsigned YW = $clog2(Y_SIZE + 1);

    logic [1:0]    phase_q, phase_d;
    logic [23:0]   residue_q, residue_d;
    logic [XW-1:0] x_cnt_q, x_cnt_d;
    logic [YW-1:0] y_cnt_q, y_cnt_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          tuser_q, tuser_d;
    logic          frame_last_q, frame_last_d;  // held word closes the frame
    logic          frame_done_q, frame_done_d;

    logic          accept;
    logic          emit;
    logic [31:0]   word;
    logic          x_last;
    logic          y_last;

    // Combinational from tready: upstream only presents a pixel while this is high.
    assign in_ready = !tvalid_q || m_axis_tready;
    assign accept   = in_valid && in_ready;
    assign x_last   = (x_cnt_q == XW'(X_SIZE - 1));
    assign y_last   = (y_cnt_q == YW'(Y_SIZE - 1));

    always_comb begin
        phase_d      = phase_q;
        residue_d    = residue_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        frame_last_d = frame_last_q;
        word         = '0;
        emit         = 1'b0;

        if (accept) begin
            phase_d = phase_q + 2'd1;
            if (x_last) begin
                x_cnt_d = '0;
                y_cnt_d = y_last ? '0 : y_cnt_q + 1'b1;
            end else begin
                x_cnt_d = x_cnt_q + 1'b1;
            end

            unique case (phase_q)
                2'd0: residue_d = {in_b, in_g, in_r};
                2'd1: begin
                    word      = {in_r, residue_q};
                    residue_d = {8'h00, in_b, in_g};
                end
                2'd2: begin
                    word      = {in_g, in_r, residue_q[15:0]};
                    residue_d = {16'h0000, in_b};
                end
                default: begin
                    word      = {in_b, in_g, in_r, residue_q[7:0]};
                    residue_d = '0;
                end
            endcase
            emit = (phase_q != 2'd0);
        end

        // A new word may replace the one being handed off in the same cycle.
        if (emit) begin
            tdata_d      = word;
            tvalid_d     = 1'b1;
            tlast_d      = x_last;
            tuser_d      = (phase_q == 2'd1) && (x_cnt_q == XW'(1)) && (y_cnt_q == '0);
            frame_last_d = x_last && y_last;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        frame_done_d = tvalid_q && m_axis_tready && frame_last_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q      <= '0;
            residue_q    <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            frame_last_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            residue_q    <= residue_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            frame_last_q <= frame_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Bench for pixel_packer (X_SIZE=8, Y_SIZE=2). The reference model is a byte
// queue: accepted pixels push R,G,B; each handshaken word must carry the next
// four bytes. Word markers come from the word index within the frame.
module tb_pixel_packer;

    localparam int unsigned XS  = 8;
    localparam int unsigned YS  = 2;
    localparam int          WPL = 3 * XS / 4;  // words per line
    localparam int          WPF = WPL * YS;    // words per frame

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tlast;
    logic        tuser;
    logic        frame_done;

    always #5 aclk = ~aclk;

    pixel_packer #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .in_r          (in_r),
        .in_g          (in_g),
        .in_b          (in_b),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .frame_done    (frame_done)
    );

    int          n_pass = 0;
    int          n_total = 0;
    byte unsigned exp_q[$];
    logic [31:0] got_words[$];
    int          got_cyc[$];
    int          cyc = 0;
    int          wcnt = 0;
    int          fd_count = 0;
    bit          fd_exp = 0;
    bit          hold_prev = 0;
    bit          last_acc = 0;
    logic [31:0] held_d;
    logic        held_l, held_u;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called once per cycle at the falling edge.
    task automatic monitor();
        logic [31:0] e;
        e = '0;
        cyc++;
        chk("in_ready", 32'(in_ready), 32'(!tvalid || tready));
        chk("frame_done", 32'(frame_done), 32'(fd_exp));
        if (frame_done === 1'b1) fd_count++;
        if (hold_prev) begin
            chk("hold_tvalid", 32'(tvalid), 32'd1);
            chk("hold_tdata", tdata, held_d);
            chk("hold_tlast", 32'(tlast), 32'(held_l));
            chk("hold_tuser", 32'(tuser), 32'(held_u));
        end
        fd_exp = 0;
        if (tvalid && tready) begin
            if (exp_q.size() < 4) begin
                chk("word_without_pixels", 32'(exp_q.size()), 32'd4);
            end else begin
                for (int k = 0; k < 4; k++) e[8*k +: 8] = exp_q.pop_front();
                chk("tdata", tdata, e);
            end
            chk("tuser", 32'(tuser), 32'((wcnt % WPF) == 0));
            chk("tlast", 32'(tlast), 32'((wcnt % WPL) == WPL - 1));
            fd_exp = ((wcnt % WPF) == WPF - 1);
            got_words.push_back(tdata);
            got_cyc.push_back(cyc);
            wcnt++;
        end
        hold_prev = tvalid && !tready;
        held_d = tdata;
        held_l = tlast;
        held_u = tuser;
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            exp_q.push_back(in_r);
            exp_q.push_back(in_g);
            exp_q.push_back(in_b);
        end
    endtask

    // Entered 1 time unit after a rising edge.
    task automatic step(input bit v, input logic [23:0] rgb, input bit rdy, input bit force_v);
        tready = rdy;
        #1;
        in_valid = v && (in_ready || force_v);
        {in_r, in_g, in_b} = rgb;
        @(negedge aclk);
        monitor();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int n, input int pct, output int cycles);
        int got;
        bit r, v;
        got = 0;
        cycles = 0;
        while (got < n && cycles < 200 * n + 100) begin
            r = ($urandom_range(99) < pct);
            v = (pct >= 100) ? 1'b1 : ($urandom_range(3) != 0);
            step(v, 24'($urandom), r, 1'b0);
            if (last_acc) got++;
            cycles++;
        end
        if (got < n) chk("send_budget", 32'(got), 32'(n));
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(1'b0, 24'h0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        aresetn = 1'b0;
        #2;
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_tuser", 32'(tuser), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge aclk);
        aresetn = 1'b1;
        exp_q.delete();
        got_words.delete();
        got_cyc.delete();
        wcnt = 0;
        fd_exp = 0;
        fd_count = 0;
        hold_prev = 0;
        @(posedge aclk);
        #1;
    endtask

    task automatic four_directed();
        step(1'b1, 24'h010203, 1'b1, 1'b0);
        step(1'b1, 24'h111213, 1'b1, 1'b0);
        step(1'b1, 24'h212223, 1'b1, 1'b0);
        step(1'b1, 24'h313233, 1'b1, 1'b0);
        step(1'b0, 24'h0, 1'b1, 1'b0);
        chk("dir_word_count", 32'(got_words.size()), 32'd3);
        if (got_words.size() == 3) begin
            chk("dir_word0", got_words[0], 32'h11030201);
            chk("dir_word1", got_words[1], 32'h22211312);
            chk("dir_word2", got_words[2], 32'h33323123);
            chk("dir_back_to_back", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
        end
    endtask

    initial begin
        int cycles;
        @(posedge aclk);
        #1;
        do_reset();

        // Directed packing of four known pixels.
        four_directed();

        // Back-pressure: stall with a word pending and illegal in_valid pulses.
        step(1'b1, 24'hA0A1A2, 1'b1, 1'b0);
        step(1'b1, 24'hB0B1B2, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 24'hEEEEEE, 1'b0, 1'b1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_tvalid", 32'(tvalid), 32'd1);
        end
        step(1'b1, 24'hC0C1C2, 1'b1, 1'b0);
        chk("release_accepted", 32'(last_acc), 32'd1);
        send(9, 100, cycles);
        drain();
        chk("stall_frame_done", 32'(fd_count), 32'd1);
        chk("stall_residue", 32'(exp_q.size()), 32'd0);

        // Full frame plus a bit at full rate from reset.
        do_reset();
        send(20, 100, cycles);
        chk("full_rate_cycles", 32'(cycles), 32'd20);
        drain();
        chk("frame_words", 32'(got_words.size()), 32'd15);
        chk("frame_done_once", 32'(fd_count), 32'd1);

        // Two frames with random back-pressure and random pixel gaps.
        do_reset();
        send(32, 50, cycles);
        drain();
        chk("rand_words", 32'(got_words.size()), 32'd24);
        chk("rand_frames", 32'(fd_count), 32'd2);
        chk("rand_leftover", 32'(exp_q.size()), 32'd0);

        // Reset with residue and an emitted word pending.
        send(2, 100, cycles);
        do_reset();
        four_directed();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
